attn_job_scheduler: RTL and testbench
=====================================

# attn_job_scheduler

Job scheduler that shares a single `pe_8x8_top` attention core between `NUM_REQ` requesters. Each requester submits one 32×16-bit key/query/value operand set. The scheduler arbitrates round-robin, latches the winning operands, and drives the core through its reset and enable sequence. It then captures `final_res` on `all_done` and returns it, tagged with the requester id, on a valid/ready response port. A watchdog aborts jobs that never complete.

## Interface
- `NUM_REQ`, 4: number of requesters; power of two, 2..8.
- `ID_W`, 2: log2(`NUM_REQ`).
- `RST_CYCLES`, 2: cycles `core_rst_n` is held low before each job; at least 1.
- `TIMEOUT`, 1024: maximum RUN cycles before the job is aborted; at least 2.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in `NUM_REQ`: per-requester job request.
- `req_ready` out `NUM_REQ`: one-hot grant; a transfer occurs on `req_valid[i] & req_ready[i]`.
- `req_key`, `req_query`, `req_value` in `NUM_REQ`×512 each: requester i occupies bits `[i*512 +: 512]`.
- `resp_valid` out 1: result available.
- `resp_ready` in 1: consumer accepts the result.
- `resp_id` out `ID_W`: requester index that owns the result.
- `resp_data` out 512: captured `final_res`; zero on error.
- `resp_err` out 1: job aborted by the watchdog.
- `core_en` out 1: drives core `en`.
- `core_rst_n` out 1: drives core `rst_n`; active-low soft reset.
- `core_key`, `core_query`, `core_value` out 512 each: registered operands.
- `core_final_res` in 512: core result.
- `core_all_done` in 1: core completion flag.
- `busy` out 1: high in every state except IDLE.
- `job_count` out 16: number of completed responses (success or error); wraps at 2^16.

## Operation
- FSM states: IDLE → RESET → RUN → RESP → IDLE.
- **IDLE:**
  - `core_en`=0 and `core_rst_n`=0.
  - If any `req_valid` is high, the grant goes to the first requester at or after `rr_ptr` in circular order.
  - The grant is combinational: `req_ready[g]`=1 in IDLE only. All other `req_ready` bits are 0.
  - On the transfer the scheduler latches `req_*[g]` into `core_*` and `g` into `resp_id`, sets `rr_ptr` to g+1 (mod `NUM_REQ`), clears the counter, and moves to RESET.
- **RESET:**
  - `core_en`=1 and `core_rst_n`=0 for exactly `RST_CYCLES` cycles, then RUN.
  - `core_all_done` is ignored in this state.
- **RUN:**
  - `core_en`=1, `core_rst_n`=1, and the cycle counter increments.
  - If `core_all_done`=1: register `resp_data` from `core_final_res` with `resp_err`=0, then go to RESP.
  - Otherwise, if the counter reaches `TIMEOUT`-1: `resp_data`=0 and `resp_err`=1, then go to RESP.
  - If `all_done` and the timeout occur in the same cycle, success wins.
- **RESP:**
  - `resp_valid`=1, `core_en`=0, `core_rst_n`=0 (core parked in reset).
  - `resp_data`, `resp_id` and `resp_err` stay stable until the handshake.
  - On `resp_valid & resp_ready`, `job_count` increments and the FSM returns to IDLE.
- `core_*` operands hold their last latched value outside RUN.
- Requester protocol: `req_valid` and the operands must stay stable until `req_ready`. Dropping `req_valid` without a grant withdraws the request with no side effects.

## Timing
- Reset values:
  - FSM state IDLE, `rr_ptr`=0, counter=0.
  - All outputs 0, including `core_rst_n`=0, `core_*` operands=0, `resp_*`=0, `busy`=0, `job_count`=0.
- Asserting `rst_n` mid-job aborts the job immediately. No response is produced and `job_count` is unchanged.
- Grant at cycle T (IDLE handshake):
  - `core_rst_n` is low in cycles T+1..T+`RST_CYCLES`.
  - RUN starts at T+`RST_CYCLES`+1.
- `core_all_done` sampled high at cycle D: `resp_valid`=1 from D+1.
- With `resp_ready` tied high: `resp_valid` is high for one cycle, IDLE follows the next cycle, and the earliest next grant is in that IDLE cycle.
- The timeout response appears `TIMEOUT` cycles after RUN entry: the counter runs 0..`TIMEOUT`-1.
- `busy` and `resp_valid` are registered. `req_ready` is combinational from the FSM state, `rr_ptr` and `req_valid`.

## Test plan
- **Single job:** requester 2 submits the dataset, and a core model asserts `all_done` 40 cycles after `rst_n` rises.
  - `req_ready`=4'b0100 for one cycle.
  - `core_rst_n` is low for 2 cycles.
  - `resp_valid` rises 1 cycle after `all_done`, with `resp_id`=2, `resp_err`=0 and `resp_data`=`final_res`.
  - `job_count`=1.
- **Round-robin:** all four `req_valid` are held high with `resp_ready`=1.
  - Grant order is 0,1,2,3,0.
  - The `resp_id` sequence matches the grant order.
- **Timeout:** the core never asserts `all_done`, with `TIMEOUT`=16.
  - `resp_err`=1 and `resp_data`=0 exactly 16 cycles after RUN entry.
  - `core_rst_n` returns to 0 in RESP.
- **Backpressure and edge events:**
  - With `resp_ready`=0 for 10 cycles, `resp_*` stay stable, no `req_ready` is asserted, and `busy`=1.
  - `all_done` in the same cycle as the timeout gives `resp_err`=0.
- **Reset mid-RUN:** assert `rst_n` low while in RUN.
  - All outputs return to 0, `core_rst_n`=0, and `job_count` is unchanged.
  - After release, the next request completes normally.
- **Withdrawal:** requester 1 raises `req_valid` while the scheduler is busy, then drops it before RESP.
  - No grant is issued to requester 1.
  - The next grant goes to the next requester whose `req_valid` is still high.

Source files
------------

// File: rtl/attn_job_scheduler.sv
// -----------------------------------------------------------------------------
// attn_job_scheduler
//
// Shares one pe_8x8_top attention core between NUM_REQ requesters. A
// round-robin arbiter picks one pending request in IDLE and latches its
// key/query/value operands. The core is then held in soft reset for
// RST_CYCLES cycles and run until it raises all_done. The captured result
// goes back on a valid/ready response port, tagged with the requester id.
// A watchdog aborts a job that runs for TIMEOUT cycles without completing.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester request handshake (ready is one-hot)
//   req_key/query/value   packed operands, requester i at [i*512 +: 512]
//   resp_valid/ready      result handshake
//   resp_id/data/err      owner, captured final_res (0 on error), abort flag
//   core_en, core_rst_n   core enable and active-low soft reset
//   core_key/query/value  registered operands driven to the core
//   core_final_res        core result
//   core_all_done         core completion flag
//   busy                  high whenever the scheduler is not idle
//   job_count             completed responses, wraps at 2^16
// -----------------------------------------------------------------------------
module attn_job_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*512-1:0] req_key,
  input  logic [NUM_REQ*512-1:0] req_query,
  input  logic [NUM_REQ*512-1:0] req_value,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [511:0]           resp_data,
  output logic                   resp_err,
  output logic                   core_en,
  output logic                   core_rst_n,
  output logic [511:0]           core_key,
  output logic [511:0]           core_query,
  output logic [511:0]           core_value,
  input  logic [511:0]           core_final_res,
  input  logic                   core_all_done,
  output logic                   busy,
  output logic [15:0]            job_count
);

  localparam int DW      = 512;
  // One counter serves both the reset hold and the watchdog.
  localparam int CNT_MAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [DW-1:0]     key_reg, key_next;
  logic [DW-1:0]     query_reg, query_next;
  logic [DW-1:0]     value_reg, value_next;
  logic [DW-1:0]     resp_data_reg, resp_data_next;
  logic [ID_W-1:0]   resp_id_reg, resp_id_next;
  logic              resp_err_reg, resp_err_next;
  logic [15:0]       job_count_reg, job_count_next;
  logic              core_en_reg, core_rst_n_reg, busy_reg, resp_valid_reg;

  // Per-requester operand views.
  logic [DW-1:0]     key_arr   [NUM_REQ];
  logic [DW-1:0]     query_arr [NUM_REQ];
  logic [DW-1:0]     value_arr [NUM_REQ];

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   cand;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
      assign key_arr[gi]   = req_key[gi*DW +: DW];
      assign query_arr[gi] = req_query[gi*DW +: DW];
      assign value_arr[gi] = req_value[gi*DW +: DW];
      // Grant is only offered while idle, so at most one job is ever in flight.
      assign req_ready[gi] = (state_reg == S_IDLE) && grant_found &&
                             (grant_idx == ID_W'(gi));
    end
  endgenerate

  // Round-robin search starting at rr_ptr. NUM_REQ is a power of two, so
  // ID_W-bit addition wraps around the requester ring for free.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = rr_ptr_reg + ID_W'(k);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    cnt_next       = cnt_reg;
    key_next       = key_reg;
    query_next     = query_reg;
    value_next     = value_reg;
    resp_data_next = resp_data_reg;
    resp_id_next   = resp_id_reg;
    resp_err_next  = resp_err_reg;
    job_count_next = job_count_reg;

    case (state_reg)
      S_IDLE: begin
        if (grant_found) begin
          key_next     = key_arr[grant_idx];
          query_next   = query_arr[grant_idx];
          value_next   = value_arr[grant_idx];
          resp_id_next = grant_idx;
          rr_ptr_next  = grant_idx + ID_W'(1);
          cnt_next     = '0;
          state_next   = S_RESET;
        end
      end

      S_RESET: begin
        // all_done is ignored here: the core is still in reset.
        if (cnt_reg == CNT_W'(RST_CYCLES - 1)) begin
          cnt_next   = '0;
          state_next = S_RUN;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      S_RUN: begin
        cnt_next = cnt_reg + CNT_W'(1);
        // Completion is tested first so it wins over a simultaneous timeout.
        if (core_all_done) begin
          resp_data_next = core_final_res;
          resp_err_next  = 1'b0;
          state_next     = S_RESP;
        end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          resp_data_next = '0;
          resp_err_next  = 1'b1;
          state_next     = S_RESP;
        end
      end

      S_RESP: begin
        if (resp_ready) begin
          job_count_next = job_count_reg + 16'd1;
          state_next     = S_IDLE;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they line up
  // exactly with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      rr_ptr_reg     <= '0;
      cnt_reg        <= '0;
      key_reg        <= '0;
      query_reg      <= '0;
      value_reg      <= '0;
      resp_data_reg  <= '0;
      resp_id_reg    <= '0;
      resp_err_reg   <= 1'b0;
      job_count_reg  <= '0;
      core_en_reg    <= 1'b0;
      core_rst_n_reg <= 1'b0;
      busy_reg       <= 1'b0;
      resp_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rr_ptr_reg     <= rr_ptr_next;
      cnt_reg        <= cnt_next;
      key_reg        <= key_next;
      query_reg      <= query_next;
      value_reg      <= value_next;
      resp_data_reg  <= resp_data_next;
      resp_id_reg    <= resp_id_next;
      resp_err_reg   <= resp_err_next;
      job_count_reg  <= job_count_next;
      core_en_reg    <= (state_next == S_RESET) || (state_next == S_RUN);
      core_rst_n_reg <= (state_next == S_RUN);
      busy_reg       <= (state_next != S_IDLE);
      resp_valid_reg <= (state_next == S_RESP);
    end
  end

  assign core_key   = key_reg;
  assign core_query = query_reg;
  assign core_value = value_reg;
  assign core_en    = core_en_reg;
  assign core_rst_n = core_rst_n_reg;
  assign busy       = busy_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_data  = resp_data_reg;
  assign resp_id    = resp_id_reg;
  assign resp_err   = resp_err_reg;
  assign job_count  = job_count_reg;

endmodule

// File: tb/tb_attn_job_scheduler.sv
// -----------------------------------------------------------------------------
// tb_attn_job_scheduler
//
// Directed bench for attn_job_scheduler. Instance u_dut (TIMEOUT=64) covers
// the normal job flow; instance u_to (TIMEOUT=16) covers watchdog behaviour.
// A tiny core model raises all_done a programmable number of cycles after
// core_rst_n rises (0 = never).
// -----------------------------------------------------------------------------
module tb_attn_job_scheduler;

  localparam int NR = 4;
  localparam int DW = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Main instance signals
  logic [NR-1:0]    req_valid, req_ready;
  logic [NR*DW-1:0] req_key, req_query, req_value;
  logic             resp_valid, resp_ready, resp_err;
  logic [1:0]       resp_id;
  logic [DW-1:0]    resp_data, core_key, core_query, core_value, core_final_res;
  logic             core_en, core_rst_n, core_all_done, busy;
  logic [15:0]      job_count;

  // Timeout instance signals
  logic [NR-1:0]    req_valid_t, req_ready_t;
  logic [NR*DW-1:0] req_key_t, req_query_t, req_value_t;
  logic             resp_valid_t, resp_ready_t, resp_err_t;
  logic [1:0]       resp_id_t;
  logic [DW-1:0]    resp_data_t, core_key_t, core_query_t, core_value_t;
  logic             core_en_t, core_rst_n_t, core_all_done_t, busy_t;
  logic [15:0]      job_count_t;

  int total = 0;
  int bad = 0;
  int exp_jobs = 0;
  int done_delay = 0;
  int done_delay_t = 0;
  int run_cnt = 0;
  int run_cnt_t = 0;
  logic [DW-1:0] final_a, final_b;

  attn_job_scheduler #(.NUM_REQ(4), .ID_W(2), .RST_CYCLES(2), .TIMEOUT(64)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_key(req_key), .req_query(req_query), .req_value(req_value),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_err(resp_err),
    .core_en(core_en), .core_rst_n(core_rst_n),
    .core_key(core_key), .core_query(core_query), .core_value(core_value),
    .core_final_res(core_final_res), .core_all_done(core_all_done),
    .busy(busy), .job_count(job_count)
  );

  attn_job_scheduler #(.NUM_REQ(4), .ID_W(2), .RST_CYCLES(2), .TIMEOUT(16)) u_to (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_t), .req_ready(req_ready_t),
    .req_key(req_key_t), .req_query(req_query_t), .req_value(req_value_t),
    .resp_valid(resp_valid_t), .resp_ready(resp_ready_t), .resp_id(resp_id_t),
    .resp_data(resp_data_t), .resp_err(resp_err_t),
    .core_en(core_en_t), .core_rst_n(core_rst_n_t),
    .core_key(core_key_t), .core_query(core_query_t), .core_value(core_value_t),
    .core_final_res(core_final_res), .core_all_done(core_all_done_t),
    .busy(busy_t), .job_count(job_count_t)
  );

  // Core model: counts cycles since its soft reset released.
  always @(posedge clk) begin
    run_cnt   <= core_rst_n   ? run_cnt + 1   : 0;
    run_cnt_t <= core_rst_n_t ? run_cnt_t + 1 : 0;
  end
  assign core_all_done   = core_rst_n   && (done_delay   != 0) && (run_cnt   == done_delay);
  assign core_all_done_t = core_rst_n_t && (done_delay_t != 0) && (run_cnt_t == done_delay_t);

  function automatic logic [DW-1:0] pat(input int i, input int kind);
    logic [DW-1:0] r;
    for (int w = 0; w < 32; w++) r[w*16 +: 16] = 16'(kind*4096 + i*256 + w);
    return r;
  endfunction

  // Waits (bounded) at negedges until resp_valid of the main instance is high.
  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (resp_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0; resp_ready = 1'b0;
    req_valid_t = '0; resp_ready_t = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || core_en !== 1'b0 || core_rst_n !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl busy=%b resp_valid=%b core_en=%b core_rst_n=%b exp all 0",
               busy, resp_valid, core_en, core_rst_n);
    end
    total++;
    if (resp_id !== 2'd0 || resp_err !== 1'b0 || resp_data !== '0 || job_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_resp id=%0d err=%b data_nz=%b job_count=%0d exp 0",
               resp_id, resp_err, |resp_data, job_count);
    end
    total++;
    if (core_key !== '0 || core_query !== '0 || core_value !== '0 || req_ready !== 4'b0) begin
      bad++;
      $display("FAIL reset_operands key_nz=%b query_nz=%b value_nz=%b req_ready=%b exp 0",
               |core_key, |core_query, |core_value, req_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("txn reset checked");
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    done_delay = 0;
    req_valid = 4'b0100;
    #1;
    total++;
    if (req_ready !== 4'b0100) begin
      bad++; $display("FAIL midrun_grant req_ready=%b exp 0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    for (int n = 0; n < 20 && !core_rst_n; n++) @(negedge clk);
    repeat (5) @(negedge clk);
    total++;
    if (core_en !== 1'b1 || core_rst_n !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL midrun_in_run core_en=%b core_rst_n=%b busy=%b exp 1 1 1",
                      core_en, core_rst_n, busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (core_en !== 1'b0 || core_rst_n !== 1'b0 || busy !== 1'b0 || resp_valid !== 1'b0 ||
        core_key !== '0 || resp_id !== 2'd0 || job_count !== 16'd0) begin
      bad++;
      $display("FAIL midrun_abort en=%b rst_n=%b busy=%b rv=%b key_nz=%b id=%0d jobs=%0d exp all 0",
               core_en, core_rst_n, busy, resp_valid, |core_key, resp_id, job_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    done_delay = 8;
    resp_ready = 1'b1;
    req_valid = 4'b1000;
    #1;
    total++;
    if (req_ready !== 4'b1000) begin
      bad++; $display("FAIL midrun_regrant req_ready=%b exp 1000", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    wait_resp(ok);
    total++;
    if (!ok || resp_id !== 2'd3 || resp_err !== 1'b0 || resp_data !== final_a) begin
      bad++; $display("FAIL midrun_after_resp ok=%b id=%0d err=%b data_ok=%b exp 1 3 0 1",
                      ok, resp_id, resp_err, resp_data === final_a);
    end
    @(negedge clk);
    exp_jobs = 1;
    total++;
    if (job_count !== 16'(exp_jobs) || busy !== 1'b0) begin
      bad++; $display("FAIL midrun_count job_count=%0d busy=%b exp %0d 0", job_count, busy, exp_jobs);
    end
    $display("txn reset_mid_run checked");
  endtask

  task automatic test_round_robin();
    bit ok;
    int ex;
    done_delay = 3;
    resp_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    for (int j = 0; j < 5; j++) begin
      ex = j % 4;
      ok = 1'b0;
      for (int n = 0; n < 50; n++) begin
        if (req_ready != 4'b0) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      total++;
      if (!ok || req_ready !== 4'(1 << ex)) begin
        bad++; $display("FAIL rr_grant%0d ok=%b req_ready=%b exp %b", j, ok, req_ready, 4'(1 << ex));
      end
      @(negedge clk);
      if (j == 4) req_valid = '0;
      total++;
      if (core_key !== pat(ex, 1) || core_value !== pat(ex, 3)) begin
        bad++; $display("FAIL rr_operands%0d key_ok=%b value_ok=%b exp requester %0d",
                        j, core_key === pat(ex, 1), core_value === pat(ex, 3), ex);
      end
      wait_resp(ok);
      total++;
      if (!ok || resp_id !== 2'(ex) || resp_err !== 1'b0) begin
        bad++; $display("FAIL rr_resp%0d ok=%b id=%0d err=%b exp id %0d err 0", j, ok, resp_id, resp_err, ex);
      end
      $display("txn round_robin job %0d granted %0d", j, ex);
    end
    @(negedge clk);
    exp_jobs += 5;
    total++;
    if (job_count !== 16'(exp_jobs) || busy !== 1'b0) begin
      bad++; $display("FAIL rr_count job_count=%0d busy=%b exp %0d 0", job_count, busy, exp_jobs);
    end
  endtask

  task automatic test_single_job();
    int low;
    int n;
    done_delay = 40;
    resp_ready = 1'b1;
    req_valid = 4'b0100;
    #1;
    total++;
    if (req_ready !== 4'b0100) begin
      bad++; $display("FAIL single_grant req_ready=%b exp 0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    total++;
    if (req_ready !== 4'b0000 || core_key !== pat(2, 1) || core_query !== pat(2, 2)) begin
      bad++; $display("FAIL single_latch req_ready=%b key_ok=%b query_ok=%b exp 0000 1 1",
                      req_ready, core_key === pat(2, 1), core_query === pat(2, 2));
    end
    low = 0;
    for (int k = 0; k < 20; k++) begin
      if (core_rst_n) break;
      low++;
      @(negedge clk);
    end
    total++;
    if (low !== 2) begin
      bad++; $display("FAIL single_rst_cycles got=%0d exp 2", low);
    end
    n = 0;
    while (!core_all_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    total++;
    if (n !== 40 || resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_err !== 1'b0 || resp_data !== final_a) begin
      bad++; $display("FAIL single_resp done_at=%0d rv=%b id=%0d err=%b data_ok=%b exp 40 1 2 0 1",
                      n, resp_valid, resp_id, resp_err, resp_data === final_a);
    end
    @(negedge clk);
    exp_jobs += 1;
    total++;
    if (job_count !== 16'(exp_jobs) || resp_valid !== 1'b0) begin
      bad++; $display("FAIL single_count job_count=%0d rv=%b exp %0d 0", job_count, resp_valid, exp_jobs);
    end
    $display("txn single_job requester 2 done");
  endtask

  task automatic test_backpressure();
    bit ok;
    done_delay = 5;
    resp_ready = 1'b0;
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    wait_resp(ok);
    total++;
    if (!ok || resp_id !== 2'd0 || resp_data !== final_a) begin
      bad++; $display("FAIL bp_resp ok=%b id=%0d data_ok=%b exp 1 0 1", ok, resp_id, resp_data === final_a);
    end
    core_final_res = final_b;
    req_valid = 4'b1000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_err !== 1'b0 || resp_data !== final_a ||
          req_ready !== 4'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL bp_hold%0d rv=%b id=%0d err=%b data_ok=%b req_ready=%b busy=%b exp 1 0 0 1 0000 1",
                        c, resp_valid, resp_id, resp_err, resp_data === final_a, req_ready, busy);
      end
    end
    core_final_res = final_a;
    req_valid = '0;
    resp_ready = 1'b1;
    @(negedge clk);
    exp_jobs += 1;
    total++;
    if (resp_valid !== 1'b0 || job_count !== 16'(exp_jobs)) begin
      bad++; $display("FAIL bp_release rv=%b job_count=%0d exp 0 %0d", resp_valid, job_count, exp_jobs);
    end
    $display("txn backpressure 10 cycles held");
  endtask

  task automatic test_withdrawal();
    bit ok;
    done_delay = 20;
    resp_ready = 1'b1;
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = 4'b1010;
    #1;
    total++;
    if (req_ready !== 4'b0) begin
      bad++; $display("FAIL wd_busy_ready req_ready=%b exp 0000", req_ready);
    end
    repeat (8) @(negedge clk);
    req_valid[1] = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (req_ready != 4'b0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    total++;
    if (!ok || req_ready !== 4'b1000) begin
      bad++; $display("FAIL wd_next_grant ok=%b req_ready=%b exp 1000", ok, req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    wait_resp(ok);
    total++;
    if (!ok || resp_id !== 2'd3) begin
      bad++; $display("FAIL wd_resp_id ok=%b id=%0d exp 3", ok, resp_id);
    end
    @(negedge clk);
    exp_jobs += 2;
    total++;
    if (job_count !== 16'(exp_jobs)) begin
      bad++; $display("FAIL wd_count job_count=%0d exp %0d", job_count, exp_jobs);
    end
    $display("txn withdrawal requester 1 skipped");
  endtask

  // Runs one job on the TIMEOUT=16 instance; returns cycles from RUN entry to resp_valid.
  task automatic run_to_job(output int n);
    resp_ready_t = 1'b1;
    req_valid_t = 4'b0010;
    @(negedge clk);
    req_valid_t = '0;
    for (int k = 0; k < 20 && !core_rst_n_t; k++) @(negedge clk);
    n = 0;
    while (!resp_valid_t && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_same_cycle();
    int n;
    done_delay_t = 15;
    run_to_job(n);
    total++;
    if (n !== 16 || resp_err_t !== 1'b0 || resp_data_t !== final_a || resp_id_t !== 2'd1) begin
      bad++; $display("FAIL same_cycle lat=%0d err=%b data_ok=%b id=%0d exp 16 0 1 1",
                      n, resp_err_t, resp_data_t === final_a, resp_id_t);
    end
    @(negedge clk);
    $display("txn same_cycle done vs timeout");
  endtask

  task automatic test_timeout();
    int n;
    done_delay_t = 0;
    run_to_job(n);
    total++;
    if (n !== 16 || resp_err_t !== 1'b1 || resp_data_t !== '0 || resp_id_t !== 2'd1) begin
      bad++; $display("FAIL timeout_resp lat=%0d err=%b data_nz=%b id=%0d exp 16 1 0 1",
                      n, resp_err_t, |resp_data_t, resp_id_t);
    end
    total++;
    if (core_rst_n_t !== 1'b0 || core_en_t !== 1'b0 || busy_t !== 1'b1) begin
      bad++; $display("FAIL timeout_park core_rst_n=%b core_en=%b busy=%b exp 0 0 1",
                      core_rst_n_t, core_en_t, busy_t);
    end
    @(negedge clk);
    total++;
    if (job_count_t !== 16'd2 || busy_t !== 1'b0) begin
      bad++; $display("FAIL timeout_count job_count=%0d busy=%b exp 2 0", job_count_t, busy_t);
    end
    $display("txn timeout job aborted");
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit reached exp finish earlier");
    $fatal(1);
  end

  initial begin
    final_a = pat(7, 3);
    final_b = pat(5, 1);
    core_final_res = final_a;
    req_key_t = '0; req_query_t = '0; req_value_t = '0;
    for (int i = 0; i < NR; i++) begin
      req_key[i*DW +: DW]   = pat(i, 1);
      req_query[i*DW +: DW] = pat(i, 2);
      req_value[i*DW +: DW] = pat(i, 3);
    end
    test_reset();
    test_reset_mid_run();
    test_round_robin();
    test_single_job();
    test_backpressure();
    test_withdrawal();
    test_same_cycle();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
